mux4_key_loader: RTL
====================

MUX4_KEY_LOADER -- requirements
Module: mux4_key_loader

Interface
REQ-001 The block SHALL have parameter NUM_GATES, default 10, meaning the number of MUX4 key gates (legal range 1..64).
REQ-002 The block SHALL have parameter REG_OUT, default 1, where 1 selects registered lut_out and 0 selects combinational lut_out.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port key_start  input  1  is a one-cycle pulse that begins a key load.
REQ-006 Port key_bit  input  1  carries the serial key data bit.
REQ-007 Port key_valid  input  1  qualifies key_bit.
REQ-008 Port key_ready  output  1  signals that a key bit is accepted this cycle.
REQ-009 Port sel_a  input  NUM_GATES  is the per-gate select LSB (first mux input).
REQ-010 Port sel_b  input  NUM_GATES  is the per-gate select MSB (second mux input).
REQ-011 Port lut_out  output  NUM_GATES  is the per-gate keyed function output.
REQ-012 Port unlocked  output  1  is high while in state ACTIVE.
REQ-013 Port key_err  output  1  is the sticky parity-failure flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, CHECK, ACTIVE and ERROR.
REQ-015 key_start=1 in any state SHALL, on the next cycle, enter LOAD, clear the key register and bit counter, and drive unlocked and key_err to 0.
REQ-016 key_ready SHALL be 1 only in LOAD; a beat is accepted when key_valid&&key_ready.
REQ-017 Accepted beats SHALL be LSB-first: beat k (k<4*NUM_GATES) writes key[k]; beats 4*NUM_GATES..4*NUM_GATES+3 write parity[0..3].
REQ-018 Idle cycles (key_valid=0) during LOAD SHALL be permitted, with no timeout.
REQ-019 Acceptance of beat 4*NUM_GATES+3 SHALL move the FSM to CHECK on the next cycle.
REQ-020 CHECK SHALL last exactly one cycle and compare the XOR of all NUM_GATES key nibbles key[4i+3:4i] with parity.
REQ-021 On match, CHECK SHALL go to ACTIVE; on mismatch it SHALL go to ERROR and clear the key register.
REQ-022 In ACTIVE, gate i's function SHALL be key[4i + {sel_b[i],sel_a[i]}]: 00->bit0, a=1/b=0->bit1, a=0/b=1->bit2, 11->bit3.
REQ-023 Outside ACTIVE, lut_out SHALL be all zeros.
REQ-024 With REG_OUT=1, lut_out SHALL reflect sel and state with one cycle of latency; with REG_OUT=0 it SHALL reflect them combinationally.
REQ-025 ERROR SHALL hold key_err=1 until key_start or reset.
REQ-026 ACTIVE and ERROR SHALL be left only via key_start or reset.
REQ-027 When key_start and key_valid occur in the same cycle, key_start SHALL win and the bit SHALL be discarded.
REQ-028 key_valid outside LOAD SHALL be ignored.
REQ-029 The bit counter SHALL be ceil(log2(4*NUM_GATES+4)) bits wide and SHALL never wrap within a load.

Reset
REQ-030 While rst_n=0, the block SHALL force state=IDLE, key=0, parity=0, counter=0, lut_out=0, unlocked=0, key_err=0 and key_ready=0, independent of clk.
REQ-031 Reset asserted mid-LOAD SHALL discard the partial key; after release the block SHALL stay in IDLE until key_start.

Verification (NUM_GATES=10)
REQ-032 Good key: key_start, then 40 beats forming nibbles 4'h8 plus parity 4'h0 -> CHECK, then unlocked=1; sel_a=sel_b=10'h3FF -> lut_out=10'h3FF, and sel_a=10'h3FF, sel_b=0 -> lut_out=0 (REG_OUT=1: one cycle later).
REQ-033 Bad parity: the same key with parity 4'h1 -> key_err=1, unlocked=0, lut_out=0, key_ready=0, with the FSM remaining in ERROR.
REQ-034 Restart: key_start issued after 17 beats, then a full valid load of 44 beats with gaps inserted -> ACTIVE, and the earlier bits have no effect.
REQ-035 Collision: key_start and key_valid in the same cycle -> counter=0 next cycle and the bit is not stored.
REQ-036 Reset mid-LOAD: after 30 beats, pulse rst_n low between clock edges -> all outputs 0 immediately; afterwards, 44 beats without key_start are ignored.
REQ-037 REG_OUT=0 instance: with the good key loaded, toggling sel_a[0] -> lut_out[0] changes in the same cycle.

Source files
------------

// File: rtl/mux4_key_loader.sv
// mux4_key_loader: serially loads a per-gate 4-bit key plus a 4-bit parity
// nibble, verifies parity, and then lets each gate act as a keyed MUX4 LUT
// selected by {sel_b[i], sel_a[i]}. A failed check locks the block in ERROR.
module mux4_key_loader #(
    parameter int NUM_GATES = 10,
    parameter bit REG_OUT   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_start,
    input  logic                 key_bit,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [NUM_GATES-1:0] sel_a,
    input  logic [NUM_GATES-1:0] sel_b,
    output logic [NUM_GATES-1:0] lut_out,
    output logic                 unlocked,
    output logic                 key_err
);

    localparam int KW = 4 * NUM_GATES;
    localparam int CW = $clog2(KW + 4);
    localparam logic [CW-1:0] LAST_BEAT = CW'(KW + 3);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t              r_state;
    logic [KW-1:0]       r_key;
    logic [3:0]          r_parity;
    logic [CW-1:0]       r_cnt;
    logic                r_key_ready;
    logic                r_unlocked;
    logic                r_key_err;
    logic [3:0]          w_nib_xor;
    logic                w_active;
    logic [NUM_GATES-1:0] w_lut;

    // Fold all key nibbles together for comparison against the parity nibble.
    always_comb begin
        w_nib_xor = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            w_nib_xor = w_nib_xor ^ r_key[4*i +: 4];
        end
    end

    // Control FSM: key_start restarts from any state and beats a same-cycle bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_parity    <= '0;
            r_cnt       <= '0;
            r_key_ready <= 1'b0;
            r_unlocked  <= 1'b0;
            r_key_err   <= 1'b0;
        end else if (key_start) begin
            r_state     <= LOAD;
            r_key       <= '0;
            r_parity    <= '0;
            r_cnt       <= '0;
            r_key_ready <= 1'b1;
            r_unlocked  <= 1'b0;
            r_key_err   <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (key_valid && r_key_ready) begin
                        for (int k = 0; k < KW; k++) begin
                            if (r_cnt == CW'(k)) r_key[k] <= key_bit;
                        end
                        for (int p = 0; p < 4; p++) begin
                            if (r_cnt == CW'(KW + p)) r_parity[p] <= key_bit;
                        end
                        // Hold the counter on the last beat so it never wraps.
                        if (r_cnt == LAST_BEAT) begin
                            r_state     <= CHECK;
                            r_key_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (w_nib_xor == r_parity) begin
                        r_state    <= ACTIVE;
                        r_unlocked <= 1'b1;
                    end else begin
                        r_state   <= ERROR;
                        r_key_err <= 1'b1;
                        r_key     <= '0;
                    end
                end
                IDLE, ACTIVE, ERROR: ;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_active  = (r_state == ACTIVE);
    assign key_ready = r_key_ready;
    assign unlocked  = r_unlocked;
    assign key_err   = r_key_err;

    // Each gate picks one bit of its own key nibble; forced low unless unlocked.
    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
        logic [3:0] w_nib;
        logic [1:0] w_sel;
        assign w_nib     = r_key[4*gi +: 4];
        assign w_sel     = {sel_b[gi], sel_a[gi]};
        assign w_lut[gi] = w_active & w_nib[w_sel];
    end

    if (REG_OUT) begin : g_reg_out
        logic [NUM_GATES-1:0] r_lut;
        // Registered LUT output: one cycle behind sel and state.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_lut <= '0;
            else        r_lut <= w_lut;
        end
        assign lut_out = r_lut;
    end else begin : g_comb_out
        assign lut_out = w_lut;
    end

endmodule
